nios_system_onchip_memory_arbiter: RTL
======================================

Name: nios_system_onchip_memory_arbiter

Overview:
- Two-master round-robin arbiter in front of the single-port on-chip RAM (32-bit data, 13-bit word address, 8000 words, 1-cycle read latency, unregistered q).
- Lets the Nios data master (m0) and a DMA/peripheral master (m1) share the one RAM port.
- Issues at most one access per cycle and routes read data back to the requester that issued the read.
- Flags and counts out-of-range accesses.

Parameters:
- ADDR_W, 13, word-address width on all ports.
- DEPTH, 8000, number of valid words; an address >= DEPTH is out of range.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- ERRCNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock; everything is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- m0_address  in  ADDR_W  requester 0 word address.
- m0_byteenable  in  4  requester 0 byte lanes.
- m0_read  in  1  requester 0 read request.
- m0_write  in  1  requester 0 write request.
- m0_writedata  in  32  requester 0 write data.
- m0_waitrequest  out  1  requester 0 stall.
- m0_readdata  out  32  requester 0 read data.
- m0_readdatavalid  out  1  requester 0 read data valid.
- m1_*  same set and directions as m0_*, for requester 1.
- mem_address  out  ADDR_W  to RAM address.
- mem_byteenable  out  4  to RAM byteenable.
- mem_chipselect  out  1  to RAM chipselect.
- mem_write  out  1  to RAM write.
- mem_writedata  out  32  to RAM writedata.
- mem_clken  out  1  to RAM clken; tied 1.
- mem_readdata  in  32  from RAM readdata.
- err_clear  in  1  clears err_flag and err_count.
- err_flag  out  1  sticky out-of-range indicator.
- err_count  out  ERRCNT_W  saturating count of out-of-range accesses.

Behaviour:
- Request: req_n = mN_read | mN_write. If both read and write are high, the access is a write; no readdatavalid follows.
- Arbitration (combinational, from req and the last_grant register):
  - Only one requester active: that requester is granted.
  - Both active: the requester not equal to last_grant is granted.
  - last_grant resets to 1, so m0 wins the first tie.
  - last_grant updates to the granted index on every cycle with a grant, and holds otherwise.
- Handshake:
  - mN_waitrequest = req_n & ~grant_n (combinational).
  - An access is accepted in the cycle its requester's waitrequest is low.
  - A requester must hold address, data and command stable while stalled.
  - Back-to-back accepts from the same requester are allowed when the other requester is idle.
- RAM drive, when a grant exists:
  - mem_address, mem_byteenable and mem_writedata are muxed from the granted requester.
  - mem_chipselect = 1.
  - mem_write = granted write & in_range.
- RAM drive, with no grant: mem_chipselect = 0, mem_write = 0, and address/data are driven from m0 (don't-care).
- Read return:
  - An accepted read sets a registered pending flag {valid, owner, oor}.
  - In the next cycle, mOwner_readdatavalid = 1 and mOwner_readdata = mem_readdata, or 32'h0 if oor was set.
  - Latency is exactly 1 cycle from accept to readdatavalid.
  - Non-owner readdatavalid stays 0. mN_readdata is 0 whenever its readdatavalid is 0.
- Out of range (address >= DEPTH) on an accepted access:
  - Writes are suppressed (mem_write = 0).
  - Reads return 0.
  - err_flag sets on the next edge.
  - err_count increments by 1 and saturates at all-ones.
  - err_clear has priority over a simultaneous increment: the result is flag = 0, count = 0.
- Reset (async, any time):
  - last_grant = 1, pending valid = 0, err_flag = 0, err_count = 0.
  - All readdatavalid outputs = 0 and all readdata outputs = 0.
  - A read in flight when reset asserts is dropped and never returned.
  - Combinational outputs follow inputs during reset, except that grants are forced to 0: all waitrequest outputs equal req_n and mem_chipselect = 0.

Test Plan:
- m0 writes 0xDEADBEEF to address 5 with byteenable 4'hF, then reads address 5 -> waitrequest 0 on both accepts; m0_readdatavalid = 1 exactly 1 cycle after the read accept, with m0_readdata = 0xDEADBEEF; m1_readdatavalid stays 0.
- m0 and m1 both hold reads to addresses 10 and 20 (prefilled 0xA, 0x14) for 4 cycles -> grants alternate m0, m1, m0, m1; each requester sees waitrequest on alternate cycles; returned data is 0xA to m0 and 0x14 to m1, each 1 cycle after its own accept.
- m1 writes 0x11223344 to address 3 with byteenable 4'b0101 over prior 0xFFFFFFFF, then reads address 3 -> returns 0xFF22FF44.
- m0 writes address 8000 and then reads address 8191 -> the RAM sees no write; the read returns 0 with readdatavalid; err_flag = 1 and err_count = 2. Then assert err_clear in the same cycle as a third out-of-range access -> err_flag = 0, err_count = 0.
- 300 out-of-range accesses -> err_count saturates at 255.
- m1 read accepted, then reset asserted mid-cycle before the return edge -> m1_readdatavalid never pulses. After reset, a tie between m0 and m1 grants m0 first.

Source files
------------

// File: rtl/nios_system_onchip_memory_arbiter.sv
// Round-robin arbiter letting two Avalon-style masters share one single-port
// on-chip RAM, with read-data routing and out-of-range access tracking.
module nios_system_onchip_memory_arbiter #(
  parameter int ADDR_W   = 13,
  parameter int DEPTH    = 8000,
  parameter int DATA_W   = 32,
  parameter int ERRCNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,

  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,

  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata,

  input  logic                  err_clear,
  output logic                  err_flag,
  output logic [ERRCNT_W-1:0]   err_count
);

  logic              req0, req1;
  logic              grant0, grant1, any_grant, sel;
  logic              last_grant;
  logic [ADDR_W-1:0] sel_address;
  logic              sel_read, sel_write;
  logic              in_range, access_oor;
  logic              pend_valid, pend_owner, pend_oor;
  logic [DATA_W-1:0] ret_data;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // On a tie the requester that did not win last time is served; no grants in reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (req0 && (!req1 || last_grant)) grant0 = 1'b1;
      else if (req1)                     grant1 = 1'b1;
    end
  end

  assign any_grant = grant0 | grant1;
  assign sel       = grant1;

  assign m0_waitrequest = req0 & ~grant0;
  assign m1_waitrequest = req1 & ~grant1;

  assign sel_address = sel ? m1_address : m0_address;
  assign sel_write   = sel ? m1_write   : m0_write;
  assign sel_read    = sel ? m1_read    : m0_read;
  assign in_range    = {1'b0, sel_address} < (ADDR_W+1)'(DEPTH);
  assign access_oor  = any_grant & ~in_range;

  assign mem_address    = sel_address;
  assign mem_byteenable = sel ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = sel ? m1_writedata  : m0_writedata;
  assign mem_chipselect = any_grant;
  assign mem_write      = any_grant & sel_write & in_range;
  assign mem_clken      = 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      pend_valid <= 1'b0;
      pend_owner <= 1'b0;
      pend_oor   <= 1'b0;
    end else begin
      if (any_grant) last_grant <= sel;
      pend_valid <= any_grant & sel_read & ~sel_write;
      pend_owner <= sel;
      pend_oor   <= ~in_range;
    end
  end

  // Clear beats a same-cycle increment; the counter sticks at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_flag  <= 1'b0;
      err_count <= '0;
    end else if (err_clear) begin
      err_flag  <= 1'b0;
      err_count <= '0;
    end else if (access_oor) begin
      err_flag <= 1'b1;
      if (err_count != {ERRCNT_W{1'b1}}) err_count <= err_count + 1'b1;
    end
  end

  assign ret_data         = pend_oor ? '0 : mem_readdata;
  assign m0_readdatavalid = pend_valid & ~pend_owner;
  assign m1_readdatavalid = pend_valid &  pend_owner;
  assign m0_readdata      = m0_readdatavalid ? ret_data : '0;
  assign m1_readdata      = m1_readdatavalid ? ret_data : '0;

endmodule
